// File: rtl/spc_link_sequencer.sv
// spc_link_sequencer
//   Sequences PC/LR/SP updates for BL, RET, CALL (LR spilled to stack) and
//   POPRET (return address filled from stack). One command in flight; decode
//   stalls on cmd_ready. Owns the stack memory request port.
//
//   Optional feature: define SPC_SEQ_TIMEOUT_EN to fault (code 11) when a
//   stack access sees no mem_ack within TIMEOUT_CYC cycles.
//
//   Ports
//     clk, reset            clock, async active-low reset
//     cmd_valid/ready/op/target   command handshake from decode
//     re_pc/re_lr/re_sp     current special register values
//     wr_{pc,lr,sp}[_data]  one-cycle write strobes + data to the regfile
//     mem_req/we/addr/wdata/rdata/ack   stack memory port
//     done                  pulse in the cycle the final strobes are driven
//     fault, fault_code     sticky error and cause; fault_clr releases it
//     depth                 outstanding CALL frames
//
//   state  | meaning
//   IDLE   | ready for a command
//   SPILL  | writing LR to SP-4, waiting for mem_ack
//   FILL   | reading return address at SP, waiting for mem_ack
//   COMMIT | driving write strobes and done for one cycle
//   FAULT  | error held until fault_clr

module spc_link_sequencer #(
    parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800,
    parameter int          DEPTH_W     = 8,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [31:0]        cmd_target,
    input  logic [31:0]        re_pc,
    input  logic [31:0]        re_lr,
    input  logic [31:0]        re_sp,
    output logic               wr_pc,
    output logic               wr_lr,
    output logic               wr_sp,
    output logic [31:0]        wr_pc_data,
    output logic [31:0]        wr_lr_data,
    output logic [31:0]        wr_sp_data,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_ack,
    output logic               done,
    output logic               fault,
    output logic [1:0]         fault_code,
    input  logic               fault_clr,
    output logic [DEPTH_W-1:0] depth
);

    typedef enum logic [2:0] {
        S_IDLE, S_SPILL, S_FILL, S_COMMIT, S_FAULT
    } state_t;

    localparam logic [1:0] OP_BL     = 2'b00;
    localparam logic [1:0] OP_RET    = 2'b01;
    localparam logic [1:0] OP_CALL   = 2'b10;
    localparam logic [1:0] OP_POPRET = 2'b11;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t state, state_nxt;

    logic [1:0]  op_q;
    logic [31:0] target_q, pc_q, lr_q, sp_q, rdata_q;
    logic [TW-1:0] tmo_cnt;
    logic        tmo_en;
    logic        tmo_expired;

`ifdef SPC_SEQ_TIMEOUT_EN
    assign tmo_en = 1'b1;
`else
    assign tmo_en = 1'b0;
`endif

    assign tmo_expired = tmo_en && (tmo_cnt == '0);

    // The borrow bit catches SP < 4, which wraps and must count as overflow.
    logic [32:0] sp_dec_ext;
    logic        call_ovf, pop_unf;
    assign sp_dec_ext = {1'b0, re_sp} - 33'd4;
    assign call_ovf   = sp_dec_ext[32] || (sp_dec_ext[31:0] < STACK_LIMIT);
    assign pop_unf    = (re_sp >= STACK_BASE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CALL:   state_nxt = call_ovf ? S_FAULT : S_SPILL;
                        OP_POPRET: state_nxt = pop_unf  ? S_FAULT : S_FILL;
                        default:   state_nxt = S_COMMIT;
                    endcase
                end
            end
            S_SPILL, S_FILL: begin
                if (mem_ack)          state_nxt = S_COMMIT;
                else if (tmo_expired) state_nxt = S_FAULT;
            end
            S_COMMIT: state_nxt = S_IDLE;
            S_FAULT:  if (fault_clr) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Command snapshot, fill data, fault cause, depth and timeout counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= OP_BL;
            target_q   <= '0;
            pc_q       <= '0;
            lr_q       <= '0;
            sp_q       <= '0;
            rdata_q    <= '0;
            fault_code <= 2'b00;
            depth      <= '0;
            tmo_cnt    <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                op_q     <= cmd_op;
                target_q <= cmd_target;
                pc_q     <= re_pc;
                lr_q     <= re_lr;
                sp_q     <= re_sp;
                tmo_cnt  <= TW'(TIMEOUT_CYC - 1);
                if (state_nxt == S_FAULT)
                    fault_code <= (cmd_op == OP_CALL) ? 2'b01 : 2'b10;
            end
            if (state == S_SPILL || state == S_FILL) begin
                if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - TW'(1);
                if (state_nxt == S_FAULT) fault_code <= 2'b11;
            end
            if (state == S_FILL && mem_ack) rdata_q <= mem_rdata;
            if (state == S_FAULT && fault_clr) fault_code <= 2'b00;
            if (state == S_COMMIT) begin
                if (op_q == OP_CALL && depth != {DEPTH_W{1'b1}})
                    depth <= depth + DEPTH_W'(1);
                else if (op_q == OP_POPRET && depth != '0)
                    depth <= depth - DEPTH_W'(1);
            end
        end
    end

    // Outputs are decoded from state so reset removes them immediately.
    always_comb begin
        cmd_ready  = (state == S_IDLE);
        fault      = (state == S_FAULT);
        wr_pc      = 1'b0;
        wr_lr      = 1'b0;
        wr_sp      = 1'b0;
        wr_pc_data = '0;
        wr_lr_data = '0;
        wr_sp_data = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        done       = 1'b0;
        case (state)
            S_SPILL: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_q - 32'd4;
                mem_wdata = lr_q;
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = sp_q;
            end
            S_COMMIT: begin
                done = 1'b1;
                case (op_q)
                    OP_BL: begin
                        wr_lr = 1'b1; wr_lr_data = pc_q + 32'd4;
                        wr_pc = 1'b1; wr_pc_data = target_q;
                    end
                    OP_RET: begin
                        wr_pc = 1'b1; wr_pc_data = lr_q;
                    end
                    OP_CALL: begin
                        wr_sp = 1'b1; wr_sp_data = sp_q - 32'd4;
                        wr_lr = 1'b1; wr_lr_data = pc_q + 32'd4;
                        wr_pc = 1'b1; wr_pc_data = target_q;
                    end
                    default: begin
                        wr_pc = 1'b1; wr_pc_data = rdata_q;
                        wr_sp = 1'b1; wr_sp_data = sp_q + 32'd4;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule
